// File: rtl/dg0045_pkg.sv
// Shared types and constants for the DG0045 machine-cycle sequencer.
// Slot timing, opcode and PC field layout live here so all files agree.
package dg0045_pkg;

   localparam int unsigned PU_W   = 4;
   localparam int unsigned PL_W   = 6;
   localparam int unsigned PC_W   = PU_W + PL_W;
   localparam int unsigned BUS_W  = PU_W + 1;
   localparam int unsigned SLOT_W = 3;
   localparam int unsigned CMD_W  = 8;

   localparam logic [CMD_W-1:0]  NOP_CODE   = CMD_W'(8'h00);
   localparam logic [SLOT_W-1:0] FETCH_SLOT = SLOT_W'(3);
   localparam logic [SLOT_W-1:0] EXEC_SLOT  = SLOT_W'(7);
   localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(7);
   localparam int unsigned       HI_SLOTS   = 2;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic [PU_W-1:0] pu;
      logic [PL_W-1:0] pl;
   } pc_t;

endpackage

// File: rtl/dg0045_cycle_sequencer_if.sv
// Core-facing bundle of the cycle sequencer: PC/ROM/run-control inputs,
// slot strobes, pad bus and instruction bytes out.
interface dg0045_cycle_sequencer_if;
   import dg0045_pkg::*;

   logic [PC_W-1:0]   pc_in;
   logic [CMD_W-1:0]  rom_data;
   logic              skip;
   logic              halt_req;
   logic              step_req;
   logic [SLOT_W-1:0] slot;
   logic              f1_en;
   logic              f2_en;
   logic              pc_mux;
   logic [BUS_W-1:0]  pc_bus;
   logic [CMD_W-1:0]  cmd_out;
   logic [CMD_W-1:0]  last_cmd;
   logic              cycle_done;
   logic              halted;

   modport master (
      output pc_in, rom_data, skip, halt_req, step_req,
      input  slot, f1_en, f2_en, pc_mux, pc_bus, cmd_out, last_cmd, cycle_done, halted
   );

   modport slave (
      input  pc_in, rom_data, skip, halt_req, step_req,
      output slot, f1_en, f2_en, pc_mux, pc_bus, cmd_out, last_cmd, cycle_done, halted
   );

endinterface

// File: rtl/dg0045_slot_counter.sv
// 8-slot machine-cycle counter; parks at slot 0 while hold is set.
// Decodes the upcoming slot so the parent can register its strobes.
module dg0045_slot_counter
   import dg0045_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   output logic [SLOT_W-1:0] slot,
   output logic              pc_mux,
   output logic              last_c,
   output logic              fetch_nxt_c,
   output logic              exec_nxt_c
);

   logic [SLOT_W-1:0] slot_q, slot_d;
   logic              pc_mux_q, pc_mux_d;

   always_comb begin
      slot_d   = hold ? '0 : slot_q + SLOT_W'(1);
      pc_mux_d = (slot_d < SLOT_W'(HI_SLOTS));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= '0;
         pc_mux_q <= (SLOT_W'(0) < SLOT_W'(HI_SLOTS));
      end else begin
         slot_q   <= slot_d;
         pc_mux_q <= pc_mux_d;
      end
   end

   assign slot        = slot_q;
   assign pc_mux      = pc_mux_q;
   assign last_c      = (slot_q == LAST_SLOT);
   assign fetch_nxt_c = (slot_d == FETCH_SLOT);
   assign exec_nxt_c  = (slot_d == EXEC_SLOT);

endmodule

// File: rtl/dg0045_cycle_sequencer.sv
// DG0045 machine-cycle controller: fetch/execute enables, PC pad multiplexing,
// instruction capture with skip-to-NOP, and halt/single-step run control.
module dg0045_cycle_sequencer
   import dg0045_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   dg0045_cycle_sequencer_if.slave bus
);

   seq_state_e        state_q, state_d;
   logic [SLOT_W-1:0] slot;
   logic              pc_mux;
   logic              last_c, fetch_nxt_c, exec_nxt_c;
   logic              running_nxt_c;

   logic              f1_en_q, f1_en_d;
   logic              f2_en_q, f2_en_d;
   logic              cycle_done_q, cycle_done_d;
   logic              halted_q, halted_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic [CMD_W-1:0]  last_q, last_d;
   logic              skip_q, skip_d;
   pc_t               pc;

   dg0045_slot_counter u_slot_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .hold        (state_q == ST_HALTED),
      .slot        (slot),
      .pc_mux      (pc_mux),
      .last_c      (last_c),
      .fetch_nxt_c (fetch_nxt_c),
      .exec_nxt_c  (exec_nxt_c)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_WARMUP;
      else        state_q <= state_d;
   end

   // FSM next state: run-control decisions fall on the slot-7 edge, except leaving HALTED
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WARMUP: if (last_c) state_d = bus.halt_req ? ST_HALTED : ST_RUN;
         ST_RUN:    if (last_c && bus.halt_req) state_d = ST_HALTED;
         ST_HALTED: begin
            if (!bus.halt_req)    state_d = ST_RUN;
            else if (bus.step_req) state_d = ST_STEP;
         end
         ST_STEP:   if (last_c) state_d = bus.halt_req ? ST_HALTED : ST_RUN;
      endcase
   end

   // FSM outputs, computed for the upcoming clock so they can be registered
   always_comb begin
      running_nxt_c = (state_d == ST_RUN) || (state_d == ST_STEP);
      f1_en_d       = running_nxt_c && fetch_nxt_c;
      f2_en_d       = running_nxt_c && exec_nxt_c;
      cycle_done_d  = f2_en_d;
      halted_d      = (state_d == ST_HALTED);
   end

   // Instruction capture and skip latch, keyed off the live strobes
   always_comb begin
      cmd_d  = cmd_q;
      last_d = last_q;
      skip_d = skip_q;
      if (f1_en_q) begin
         last_d = cmd_q;
         cmd_d  = skip_q ? NOP_CODE : bus.rom_data;
         skip_d = 1'b0;
      end
      if (f2_en_q) skip_d = bus.skip;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f1_en_q      <= 1'b0;
         f2_en_q      <= 1'b0;
         cycle_done_q <= 1'b0;
         halted_q     <= 1'b0;
         cmd_q        <= NOP_CODE;
         last_q       <= NOP_CODE;
         skip_q       <= 1'b0;
      end else begin
         f1_en_q      <= f1_en_d;
         f2_en_q      <= f2_en_d;
         cycle_done_q <= cycle_done_d;
         halted_q     <= halted_d;
         cmd_q        <= cmd_d;
         last_q       <= last_d;
         skip_q       <= skip_d;
      end
   end

   assign pc             = pc_t'(bus.pc_in);
   assign bus.pc_bus     = pc_mux ? {pc.pu, pc.pl[PL_W-1]} : pc.pl[BUS_W-1:0];
   assign bus.slot       = slot;
   assign bus.pc_mux     = pc_mux;
   assign bus.f1_en      = f1_en_q;
   assign bus.f2_en      = f2_en_q;
   assign bus.cycle_done = cycle_done_q;
   assign bus.halted     = halted_q;
   assign bus.cmd_out    = cmd_q;
   assign bus.last_cmd   = last_q;

endmodule

// File: tb/tb_dg0045_cycle_sequencer.sv
// Scoreboard bench for the DG0045 cycle sequencer: stimulus queues expected
// strobes, a negedge monitor pops and checks them as the DUT issues them.
module tb_dg0045_cycle_sequencer;

   typedef struct packed {
      logic       is_exec;
      logic [7:0] cmd;
      logic [7:0] last;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   dg0045_cycle_sequencer_if bus ();

   dg0045_cycle_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_run(input logic [7:0] cmd, input logic [7:0] last);
      exp_t e;
      e = '{is_exec: 1'b0, cmd: 8'h00, last: 8'h00};
      exp_q.push_back(e);
      e = '{is_exec: 1'b1, cmd: cmd, last: last};
      exp_q.push_back(e);
   endtask

   // Drives one machine cycle starting from a negedge in slot 0
   task automatic run_cycle(input logic [7:0] rom, input bit skp, input int halt_at,
                            input int step_at, input int nslots);
      for (int s = 0; s < nslots; s++) begin
         chk("slot", 32'(bus.slot), 32'(s));
         chk("halted_running", 32'(bus.halted), 32'd0);
         chk("pc_mux", 32'(bus.pc_mux), (s < 2) ? 32'd1 : 32'd0);
         chk("pc_bus", 32'(bus.pc_bus), (s < 2) ? 32'h15 : 32'h13);
         bus.rom_data = rom;
         bus.skip     = (s == 7) ? skp : 1'b0;
         if (s == halt_at) bus.halt_req = 1'b1;
         bus.step_req = (s == step_at);
         @(negedge clk);
      end
      bus.skip     = 1'b0;
      bus.step_req = 1'b0;
   endtask

   task automatic idle(input int n, input logic [7:0] cmd, input logic [7:0] last);
      for (int i = 0; i < n; i++) begin
         chk("halted", 32'(bus.halted), 32'd1);
         chk("halted_slot", 32'(bus.slot), 32'd0);
         chk("halted_cmd_out", 32'(bus.cmd_out), 32'(cmd));
         chk("halted_last_cmd", 32'(bus.last_cmd), 32'(last));
         @(negedge clk);
      end
   endtask

   task automatic check_reset();
      chk("rst_slot", 32'(bus.slot), 32'd0);
      chk("rst_f1_en", 32'(bus.f1_en), 32'd0);
      chk("rst_f2_en", 32'(bus.f2_en), 32'd0);
      chk("rst_cycle_done", 32'(bus.cycle_done), 32'd0);
      chk("rst_cmd_out", 32'(bus.cmd_out), 32'h00);
      chk("rst_last_cmd", 32'(bus.last_cmd), 32'h00);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_pc_mux", 32'(bus.pc_mux), 32'd1);
      chk("rst_pc_bus", 32'(bus.pc_bus), 32'h15);
   endtask

   // Monitor: every strobe must match the next queued expectation
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && (bus.f1_en || bus.f2_en || bus.cycle_done)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got f1=%0b f2=%0b done=%0b slot=%0d expected none at %0t",
                     bus.f1_en, bus.f2_en, bus.cycle_done, bus.slot, $time);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_f1_en", 32'(bus.f1_en), 32'(!e.is_exec));
            chk("strobe_f2_en", 32'(bus.f2_en), 32'(e.is_exec));
            chk("strobe_cycle_done", 32'(bus.cycle_done), 32'(e.is_exec));
            chk("strobe_slot", 32'(bus.slot), e.is_exec ? 32'd7 : 32'd3);
            if (e.is_exec) begin
               chk("exec_cmd_out", 32'(bus.cmd_out), 32'(e.cmd));
               chk("exec_last_cmd", 32'(bus.last_cmd), 32'(e.last));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      bus.pc_in    = 10'b1010_110011;
      bus.rom_data = 8'h0C;
      bus.skip     = 1'b0;
      bus.halt_req = 1'b0;
      bus.step_req = 1'b0;
      repeat (3) @(negedge clk);
      check_reset();
      rst_n = 1'b1;

      // Warm-up cycle: any strobe here is unexpected
      run_cycle(8'h0C, 1'b0, -1, -1, 8);

      // Capture, single skip, then consecutive skips
      push_run(8'h0C, 8'h00); run_cycle(8'h0C, 1'b1, -1, -1, 8);
      push_run(8'h00, 8'h0C); run_cycle(8'h31, 1'b0, -1, -1, 8);
      push_run(8'h31, 8'h00); run_cycle(8'h31, 1'b0, -1, -1, 8);
      push_run(8'h55, 8'h31); run_cycle(8'h55, 1'b1, -1, -1, 8);
      push_run(8'h00, 8'h55); run_cycle(8'h66, 1'b1, -1, -1, 8);
      push_run(8'h00, 8'h00); run_cycle(8'h77, 1'b0, -1, -1, 8);
      push_run(8'h88, 8'h00); run_cycle(8'h88, 1'b0, -1, -1, 8);

      // Halt raised mid-cycle: cycle completes, then frozen
      push_run(8'h0A, 8'h88); run_cycle(8'h0A, 1'b0, 5, -1, 8);
      idle(20, 8'h0A, 8'h88);

      // Single step; a second step request inside the step is dropped
      bus.rom_data = 8'h40;
      bus.step_req = 1'b1;
      @(negedge clk);
      bus.step_req = 1'b0;
      push_run(8'h40, 8'h0A); run_cycle(8'h40, 1'b0, -1, 2, 8);
      idle(6, 8'h40, 8'h0A);

      // Resume; step_req while running is ignored
      bus.halt_req = 1'b0;
      @(negedge clk);
      push_run(8'h12, 8'h40); run_cycle(8'h12, 1'b0, -1, 1, 8);
      push_run(8'h23, 8'h12); run_cycle(8'h23, 1'b0, 5, -1, 8);
      idle(3, 8'h23, 8'h12);

      // Reset in slot 5 of a step cycle
      bus.rom_data = 8'h5A;
      bus.step_req = 1'b1;
      @(negedge clk);
      bus.step_req = 1'b0;
      begin
         exp_t f;
         f = '{is_exec: 1'b0, cmd: 8'h00, last: 8'h00};
         exp_q.push_back(f);
      end
      run_cycle(8'h5A, 1'b0, -1, -1, 5);
      chk("step_cmd_out", 32'(bus.cmd_out), 32'h5A);
      chk("step_last_cmd", 32'(bus.last_cmd), 32'h23);
      rst_n = 1'b0;
      #1;
      check_reset();
      bus.halt_req = 1'b0;
      bus.rom_data = 8'h0C;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle(8'h0C, 1'b0, -1, -1, 8);
      push_run(8'h0C, 8'h00); run_cycle(8'h0C, 1'b0, -1, -1, 8);

      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
